alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the MIPS datapath. It is the successor to the single-cycle 32-bit ALU and adds the following:
- configurable width
- a Start/Busy/Done handshake
- registered results
- signed and unsigned compare
- signed-overflow flag
- an iterative multiplier producing a full double-width product
- an optional iterative unsigned divider

It sits in the EX stage. The pipeline control stalls on Busy.

---
 rtl/alu_mc.sv | 184 ++++++++++++++++++
 tb/tb_alu_mc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU for the EX stage.
// Single-cycle ops (AND/OR/ADD/SUB/SLT/SLTU) finish one edge after Start.
// MUL runs an iterative shift-add multiplier that takes WIDTH steps.
// With ALU_DIV_EN defined, opcode 111 runs an iterative restoring unsigned
// divider. Without it, opcode 111 returns zero in one cycle.
// All outputs are registered. Start is only sampled while Busy is low.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  input  logic [2:0]       ALU_Control,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] Hi_Result,
  output logic             Zero_Flag,
  output logic             Overflow_Flag,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLTU = 3'b011,
    OP_SUB  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SLT  = 3'b110,
    OP_DIVU = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;   // MUL: running high half; DIVU: partial remainder
  logic [WIDTH-1:0]   r_mq;    // MUL: multiplier shifting into low half; DIVU: dividend -> quotient
  logic [WIDTH-1:0]   r_b;     // captured operand B (multiplicand / divisor)
`ifdef ALU_DIV_EN
  logic               r_is_div;
`endif

  op_e                w_op;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_hi;
  logic               w_ovf;
  logic               w_multi;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_next_acc;
  logic [WIDTH-1:0]   w_next_mq;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
`endif

  assign w_op  = op_e'(ALU_Control);
  assign w_add = Src1 + Src2;
  assign w_sub = Src1 - Src2;

  // Single-cycle result and overflow, and whether the request needs the iterative unit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave one unassigned and infer a latch.
    w_res   = '0;
    w_hi    = '0;
    w_ovf   = 1'b0;
    w_multi = 1'b0;
    case (w_op)
      OP_AND:  w_res = Src1 & Src2;
      OP_OR:   w_res = Src1 | Src2;
      OP_ADD: begin
        w_res = w_add;
        w_ovf = (Src1[WIDTH-1] == Src2[WIDTH-1]) && (w_add[WIDTH-1] != Src1[WIDTH-1]);
      end
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (Src1 < Src2)};
      OP_SUB: begin
        w_res = w_sub;
        w_ovf = (Src1[WIDTH-1] != Src2[WIDTH-1]) && (w_sub[WIDTH-1] != Src1[WIDTH-1]);
      end
      OP_MUL:  w_multi = 1'b1;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(Src1) < $signed(Src2))};
      OP_DIVU: begin
`ifdef ALU_DIV_EN
        // Divide by zero short-circuits: all-ones quotient, dividend as remainder.
        if (Src2 == '0) begin
          w_res = '1;
          w_hi  = Src1;
        end else begin
          w_multi = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // One iteration of the shift-add multiplier or the restoring divider.
  always_comb begin
    w_mul_sum  = r_mq[0] ? ({1'b0, r_acc} + {1'b0, r_b}) : {1'b0, r_acc};
    w_next_acc = w_mul_sum[WIDTH:1];
    w_next_mq  = {w_mul_sum[0], r_mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
    // and a successful subtract always fits back into WIDTH bits.
    w_shift = {r_acc, r_mq[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    w_diff  = w_shift[WIDTH-1:0] - r_b;
    if (r_is_div) begin
      w_next_acc = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_next_mq  = {r_mq[WIDTH-2:0], w_ge};
    end
`endif
  end

  // Control FSM with registered outputs; accepts requests only in IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the datapath registers are reset too; they are few and it keeps a reset mid-RUN fully deterministic.
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_mq          <= '0;
      r_b           <= '0;
`ifdef ALU_DIV_EN
      r_is_div      <= 1'b0;
`endif
      ALU_Result    <= '0;
      Hi_Result     <= '0;
      Zero_Flag     <= 1'b1;
      Overflow_Flag <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (w_multi) begin
              r_acc   <= '0;
              r_mq    <= Src1;
              r_b     <= Src2;
              r_cnt   <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
              r_is_div <= (w_op == OP_DIVU);
`endif
              Busy    <= 1'b1;
              r_state <= S_RUN;
            end else begin
              ALU_Result    <= w_res;
              Hi_Result     <= w_hi;
              Zero_Flag     <= (w_res == '0);
              Overflow_Flag <= w_ovf;
              Done          <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_next_acc;
          r_mq  <= w_next_mq;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            ALU_Result    <= w_next_mq;
            Hi_Result     <= w_next_acc;
            Zero_Flag     <= (w_next_mq == '0);
            Overflow_Flag <= 1'b0;
            Done          <= 1'b1;
            Busy          <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc at WIDTH=32.
// Expected values come from a behavioural model using wide integer
// arithmetic. Define ALU_DIV_EN for both bench and design to cover the divider.
module tb_alu_mc;

  localparam logic [2:0] AND_OP  = 3'b000;
  localparam logic [2:0] OR_OP   = 3'b001;
  localparam logic [2:0] ADD_OP  = 3'b010;
  localparam logic [2:0] SLTU_OP = 3'b011;
  localparam logic [2:0] SUB_OP  = 3'b100;
  localparam logic [2:0] MUL_OP  = 3'b101;
  localparam logic [2:0] SLT_OP  = 3'b110;
  localparam logic [2:0] DIVU_OP = 3'b111;

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [2:0]  alu_ctl;
  logic [31:0] ALU_Result;
  logic [31:0] Hi_Result;
  logic        Zero_Flag;
  logic        Overflow_Flag;
  logic        Busy;
  logic        Done;

  int checks   = 0;
  int failures = 0;

  alu_mc #(.WIDTH(32)) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .Start         (start),
    .Src1          (src1),
    .Src2          (src2),
    .ALU_Control   (alu_ctl),
    .ALU_Result    (ALU_Result),
    .Hi_Result     (Hi_Result),
    .Zero_Flag     (Zero_Flag),
    .Overflow_Flag (Overflow_Flag),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, secondary result, overflow and latency (edges from the
  // Start edge through the edge that raises Done, inclusive).
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic ovf, output int lat);
    longint      s;
    logic [63:0] p;
    lo = '0; hi = '0; ovf = 1'b0; lat = 1;
    case (op)
      AND_OP:  lo = a & b;
      OR_OP:   lo = a | b;
      ADD_OP: begin
        s   = longint'($signed(a)) + longint'($signed(b));
        lo  = a + b;
        ovf = (s > S_MAX) || (s < S_MIN);
      end
      SUB_OP: begin
        s   = longint'($signed(a)) - longint'($signed(b));
        lo  = a - b;
        ovf = (s > S_MAX) || (s < S_MIN);
      end
      SLTU_OP: lo = (a < b) ? 32'd1 : 32'd0;
      SLT_OP:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      MUL_OP: begin
        p   = {32'd0, a} * {32'd0, b};
        lo  = p[31:0];
        hi  = p[63:32];
        lat = 33;
      end
      default: begin
`ifdef ALU_DIV_EN
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo  = a / b;
          hi  = a % b;
          lat = 33;
        end
`endif
      end
    endcase
  endfunction

  // Present a request at a falling edge; it is sampled at the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    @(negedge clk);
    alu_ctl = op; src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Called at the first falling edge after the accept edge. Waits (bounded)
  // for Done and checks results, latency, Busy and output hold. Optionally
  // pulses Start mid-run, or chains a new request while Done is high.
  task automatic wait_result(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int pulse_at, input bit chain,
                             input logic [2:0] op2, input logic [31:0] a2, input logic [31:0] b2);
    logic [31:0] e_lo, e_hi, held_lo, held_hi;
    logic        e_ovf;
    int          e_lat, n, busy_cnt;
    bit          moved;
    model(op, a, b, e_lo, e_hi, e_ovf, e_lat);
    n = 1; busy_cnt = 0; moved = 1'b0;
    held_lo = ALU_Result; held_hi = Hi_Result;
    while (Done !== 1'b1 && n < 100) begin
      if (Busy === 1'b1) busy_cnt++;
      if (ALU_Result !== held_lo || Hi_Result !== held_hi) moved = 1'b1;
      if (n == pulse_at) begin
        alu_ctl = ADD_OP; src1 = $urandom; src2 = $urandom; start = 1'b1;
      end
      @(negedge clk);
      if (n == pulse_at) start = 1'b0;
      n++;
    end
    check({tag, " done"},     64'(Done), 64'(1));
    check({tag, " latency"},  64'(n), 64'(e_lat));
    check({tag, " result"},   64'(ALU_Result), 64'(e_lo));
    check({tag, " hi"},       64'(Hi_Result), 64'(e_hi));
    check({tag, " zero"},     64'(Zero_Flag), 64'(e_lo == 32'd0));
    check({tag, " ovf"},      64'(Overflow_Flag), 64'(e_ovf));
    check({tag, " busy_end"}, 64'(Busy), 64'(0));
    check({tag, " busy_cyc"}, 64'(busy_cnt), 64'(e_lat - 1));
    check({tag, " hold"},     64'(moved), 64'(0));
    if (chain) begin
      alu_ctl = op2; src1 = a2; src2 = b2; start = 1'b1;
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    if (chain) start = 1'b0;
    check({tag, " pulse"}, 64'(Done), 64'(0));
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b0);
    wait_result(tag, op, a, b, 0, 1'b0, AND_OP, 32'd0, 32'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    rst_n = 1'b0; start = 1'b0; alu_ctl = '0; src1 = '0; src2 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst busy", 64'(Busy), 64'(0));
    check("rst done", 64'(Done), 64'(0));
    check("rst res",  64'(ALU_Result), 64'(0));
    check("rst hi",   64'(Hi_Result), 64'(0));
    check("rst zero", 64'(Zero_Flag), 64'(1));
    check("rst ovf",  64'(Overflow_Flag), 64'(0));
    rst_n = 1'b1;

    // Directed arithmetic and flag cases.
    run("add_ovf",  ADD_OP,  32'h7FFF_FFFF, 32'h0000_0001);
    run("sub_zero", SUB_OP,  32'd5,         32'd5);
    run("sub_ovf",  SUB_OP,  32'h8000_0000, 32'd1);
    run("slt",      SLT_OP,  32'hFFFF_FFFF, 32'd1);
    run("sltu",     SLTU_OP, 32'hFFFF_FFFF, 32'd1);
    run("and",      AND_OP,  32'hF0F0_1234, 32'h0FF0_FFFF);
    run("or",       OR_OP,   32'hF000_0000, 32'h0000_000F);
    run("mul_max",  MUL_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("divu",     DIVU_OP, 32'd100,       32'd7);
    run("divu_z",   DIVU_OP, 32'd9,         32'd0);
    run("mul_max2", MUL_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Asynchronous reset mid-MUL, 10 cycles after Start.
    issue(MUL_OP, 32'd12345, 32'd6789, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(Busy), 64'(0));
    check("midrst done", 64'(Done), 64'(0));
    check("midrst res",  64'(ALU_Result), 64'(0));
    check("midrst hi",   64'(Hi_Result), 64'(0));
    check("midrst zero", 64'(Zero_Flag), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst idle", 64'(Done), 64'(0));
    run("post_rst_add", ADD_OP, 32'd2, 32'd3);

    // Start pulsed during RUN is ignored.
    issue(MUL_OP, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_result("run_pulse", MUL_OP, 32'h1234_5678, 32'h9ABC_DEF0, 6, 1'b0, AND_OP, 32'd0, 32'd0);
    @(negedge clk);
    check("run_pulse quiet", 64'(Done), 64'(0));

    // Start held high across Done: second request accepted back to back.
    issue(MUL_OP, 32'd40000, 32'd70000, 1'b1);
    wait_result("b2b first", MUL_OP, 32'd40000, 32'd70000, 0, 1'b1, MUL_OP, 32'hDEAD_BEEF, 32'd3);
    wait_result("b2b second", MUL_OP, 32'hDEAD_BEEF, 32'd3, 0, 1'b0, AND_OP, 32'd0, 32'd0);

    // Randomized requests against the model.
    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = r_a;
        2:       r_b = 32'($urandom_range(1, 255));
        default: r_b = $urandom;
      endcase
      run($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
